// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear systolic array of Smith-Waterman PEs: loads the query,
// streams the reference through the chain and tracks the best last-row score.
module sw_array_ctrl #(
  parameter int N_PE   = 16,
  parameter int WIDTH  = 10,
  parameter int LEN_W  = 16,
  parameter int INIT_E = -(2 ** (WIDTH - 2))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] ref_len,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [1:0]       q_base,
  input  logic             ref_valid,
  output logic             ref_ready,
  input  logic [1:0]       ref_base,
  output logic [1:0]       pe_S,
  output logic             pe_store_S,
  output logic [1:0]       pe_T,
  output logic             pe_init,
  output logic [WIDTH-1:0] pe_init_V,
  output logic [WIDTH-1:0] pe_init_E,
  input  logic [WIDTH-1:0] pe_V_last,
  input  logic             pe_init_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] best_score,
  output logic [LEN_W-1:0] best_col
);

  localparam int CNT_W = $clog2(N_PE + 2);
  localparam int IDX_W = $clog2(N_PE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_Q = 3'd1,
    S_PLAY_Q = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic [LEN_W-1:0]   acc_r, acc_s;
  logic [LEN_W-1:0]   col_r, col_s;
  logic [1:0]         buf_r [N_PE];
  logic               buf_we_s;
  logic [IDX_W-1:0]   play_idx_s;

  logic               q_ready_s, ref_ready_s, pe_store_S_s, pe_init_s;
  logic [1:0]         pe_S_s, pe_T_s;
  logic               busy_s, done_s, err_s;
  logic [WIDTH-1:0]   best_score_s;
  logic [LEN_W-1:0]   best_col_s;

  // Next-state, next-output and score-monitor logic
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    len_s        = len_r;
    acc_s        = acc_r;
    col_s        = col_r;
    err_s        = err;
    best_score_s = best_score;
    best_col_s   = best_col;
    buf_we_s     = 1'b0;
    q_ready_s    = 1'b0;
    ref_ready_s  = 1'b0;
    pe_store_S_s = 1'b0;
    pe_S_s       = 2'd0;
    pe_init_s    = 1'b0;
    pe_T_s       = 2'd0;
    done_s       = 1'b0;
    // buf[N_PE-1] goes out first so that buf[i] ends up in PE i
    play_idx_s   = IDX_W'(N_PE - 1) - cnt_r[IDX_W-1:0];

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s      = S_LOAD_Q;
          len_s        = ref_len;
          cnt_s        = {CNT_W{1'b0}};
          acc_s        = {LEN_W{1'b0}};
          col_s        = {LEN_W{1'b0}};
          err_s        = 1'b0;
          best_score_s = {WIDTH{1'b0}};
          best_col_s   = {LEN_W{1'b0}};
          q_ready_s    = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD_Q: begin
        if (q_valid && q_ready) begin
          buf_we_s = 1'b1;
          if (cnt_r == CNT_W'(N_PE - 1)) begin
            state_s = S_PLAY_Q;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s     = cnt_r + CNT_W'(1);
            q_ready_s = 1'b1;
          end
        end else begin
          q_ready_s = 1'b1;
        end
      end
      S_PLAY_Q: begin
        pe_store_S_s = 1'b1;
        pe_S_s       = buf_r[play_idx_s];
        if (cnt_r == CNT_W'(N_PE - 1)) begin
          cnt_s = {CNT_W{1'b0}};
          if (len_r == {LEN_W{1'b0}}) begin
            state_s = S_DRAIN;
          end else begin
            state_s     = S_RUN;
            ref_ready_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_RUN: begin
        // A PE cannot stall, so a missing base ends the job with err set
        if (ref_valid) begin
          pe_init_s = 1'b1;
          pe_T_s    = ref_base;
          acc_s     = acc_r + LEN_W'(1);
          if (acc_r == len_r - LEN_W'(1)) begin
            state_s = S_DRAIN;
          end else begin
            ref_ready_s = 1'b1;
          end
        end else begin
          err_s   = 1'b1;
          state_s = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_r == CNT_W'(N_PE)) begin
          state_s = S_DONE;
          done_s  = 1'b1;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Strict > keeps the earliest column on ties
    if ((state_r == S_RUN || state_r == S_DRAIN) && pe_init_last) begin
      col_s = col_r + LEN_W'(1);
      if ($signed(pe_V_last) > $signed(best_score)) begin
        best_score_s = pe_V_last;
        best_col_s   = col_r + LEN_W'(1);
      end else begin
        best_score_s = best_score;
      end
    end else begin
      col_s = col_s;
    end

    busy_s = (state_s != S_IDLE);
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      acc_r      <= {LEN_W{1'b0}};
      col_r      <= {LEN_W{1'b0}};
      q_ready    <= 1'b0;
      ref_ready  <= 1'b0;
      pe_S       <= 2'd0;
      pe_store_S <= 1'b0;
      pe_T       <= 2'd0;
      pe_init    <= 1'b0;
      pe_init_V  <= {WIDTH{1'b0}};
      pe_init_E  <= WIDTH'(INIT_E);
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      best_score <= {WIDTH{1'b0}};
      best_col   <= {LEN_W{1'b0}};
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      len_r      <= len_s;
      acc_r      <= acc_s;
      col_r      <= col_s;
      q_ready    <= q_ready_s;
      ref_ready  <= ref_ready_s;
      pe_S       <= pe_S_s;
      pe_store_S <= pe_store_S_s;
      pe_T       <= pe_T_s;
      pe_init    <= pe_init_s;
      pe_init_V  <= {WIDTH{1'b0}};
      pe_init_E  <= WIDTH'(INIT_E);
      busy       <= busy_s;
      done       <= done_s;
      err        <= err_s;
      best_score <= best_score_s;
      best_col   <= best_col_s;
    end
  end

  // Query buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PE; i++) begin
        buf_r[i] <= 2'd0;
      end
    end else if (buf_we_s) begin
      buf_r[cnt_r[IDX_W-1:0]] <= q_base;
    end else begin
      buf_r <= buf_r;
    end
  end

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Self-checking bench for sw_array_ctrl: emulates the PE chain with a Smith-Waterman
// model and checks sequencing and best-score reporting against that model.
module tb_sw_array_ctrl;

  localparam int N    = 4;
  localparam int W    = 10;
  localparam int LW   = 16;
  localparam int MAXR = 32;
  localparam int MATCH = 2, MISM = -1, GAP_OPEN = 3, GAP_EXT = 1, NEG = -1000;

  logic          clk, rst, start, q_valid, q_ready, ref_valid, ref_ready;
  logic [LW-1:0] ref_len, best_col;
  logic [1:0]    q_base, ref_base, pe_S, pe_T;
  logic          pe_store_S, pe_init, pe_init_last, busy, done, err;
  logic [W-1:0]  pe_init_V, pe_init_E, pe_V_last, best_score;

  sw_array_ctrl #(.N_PE(N), .WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .ref_len(ref_len),
    .q_valid(q_valid), .q_ready(q_ready), .q_base(q_base),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_base(ref_base),
    .pe_S(pe_S), .pe_store_S(pe_store_S), .pe_T(pe_T), .pe_init(pe_init),
    .pe_init_V(pe_init_V), .pe_init_E(pe_init_E),
    .pe_V_last(pe_V_last), .pe_init_last(pe_init_last),
    .busy(busy), .done(done), .err(err),
    .best_score(best_score), .best_col(best_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] qry  [N];
  logic [1:0] refs [MAXR];

  // Local alignment score of the full query ending at reference column k (affine gaps)
  function automatic int sw_score(input logic [1:0] q [N], input logic [1:0] r [MAXR], input int k);
    int h [0:N][0:MAXR];
    int e [0:N][0:MAXR];
    int f [0:N][0:MAXR];
    int d;
    for (int i = 0; i <= N; i++)
      for (int j = 0; j <= k; j++) begin
        h[i][j] = 0; e[i][j] = NEG; f[i][j] = NEG;
      end
    for (int j = 1; j <= k; j++)
      for (int i = 1; i <= N; i++) begin
        e[i][j] = (e[i][j-1] - GAP_EXT > h[i][j-1] - GAP_OPEN) ? e[i][j-1] - GAP_EXT : h[i][j-1] - GAP_OPEN;
        f[i][j] = (f[i-1][j] - GAP_EXT > h[i-1][j] - GAP_OPEN) ? f[i-1][j] - GAP_EXT : h[i-1][j] - GAP_OPEN;
        d = h[i-1][j-1] + ((q[i-1] == r[j-1]) ? MATCH : MISM);
        h[i][j] = 0;
        if (d > h[i][j]) h[i][j] = d;
        if (e[i][j] > h[i][j]) h[i][j] = e[i][j];
        if (f[i][j] > h[i][j]) h[i][j] = f[i][j];
      end
    return h[N][k];
  endfunction

  // Expected best last-row score and first column reaching it over k columns
  function automatic void model_best(input int k, output int bs, output int bc);
    int v;
    bs = 0; bc = 0;
    for (int j = 1; j <= k; j++) begin
      v = sw_score(qry, refs, j);
      if (v > bs) begin bs = v; bc = j; end
    end
  endfunction

  // PE chain stand-in: S shift chain, N-cycle init lag, V from the model on what was delivered
  logic [1:0]   s_reg  [N];
  logic [1:0]   t_hist [MAXR];
  logic [N-1:0] init_dly;
  int           t_cnt, emu_col;
  assign pe_init_last = init_dly[N-1];

  always @(posedge clk) begin
    if (rst) begin
      init_dly <= '0; t_cnt <= 0; emu_col <= 0; pe_V_last <= '0;
    end else begin
      init_dly <= {init_dly[N-2:0], pe_init};
      if (pe_store_S) begin
        s_reg[0] <= pe_S;
        for (int i = 1; i < N; i++) s_reg[i] <= s_reg[i-1];
      end
      if (pe_init && t_cnt < MAXR) begin
        t_hist[t_cnt] <= pe_T;
        t_cnt <= t_cnt + 1;
      end
      if (init_dly[N-2]) begin
        pe_V_last <= W'(sw_score(s_reg, t_hist, emu_col + 1));
        emu_col   <= emu_col + 1;
      end else begin
        pe_V_last <= '0;
      end
      if (!busy) begin t_cnt <= 0; emu_col <= 0; end
    end
  end

  // Results of the last job
  logic [1:0]  r_store_q[$];
  int          r_store_runs, r_init_cnt, r_init_runs, r_done_cnt, r_last_init, r_last_store, r_done_cyc;
  logic        r_err, r_qready_late, r_busy_after, r_busy_drop, r_timeout;
  logic [W-1:0]  r_best, r_rst_E;
  logic [LW-1:0] r_col;
  logic [46:0]   r_rst_outs;

  task automatic run_job(input int len, input int nsup, input int qgap, input bit qrand,
                         input bit start_busy, input int rst_after);
    int  qi, ri, gap_left, last_acc;
    bit  prev_store, prev_init, finished;
    r_store_q.delete();
    r_store_runs = 0; r_init_cnt = 0; r_init_runs = 0; r_done_cnt = 0;
    r_last_init = -1; r_last_store = -1; r_done_cyc = -1;
    r_err = 1'b0; r_qready_late = 1'b1; r_busy_after = 1'b1; r_busy_drop = 1'b0; r_timeout = 1'b0;
    r_best = '0; r_col = '0; r_rst_outs = '1; r_rst_E = '0;
    qi = 0; ri = 0; gap_left = 0; last_acc = -10;
    prev_store = 1'b0; prev_init = 1'b0; finished = 1'b0;
    @(negedge clk);
    start = 1'b1; ref_len = LW'(len);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      if (rst) begin
        r_rst_outs = {q_ready, ref_ready, pe_S, pe_store_S, pe_T, pe_init, pe_init_V,
                      busy, done, err, best_score, best_col};
        r_rst_E = pe_init_E;
        rst = 1'b0;
        finished = 1'b1;
      end else begin
        if (pe_store_S) begin
          r_store_q.push_back(pe_S);
          r_last_store = cyc;
          if (!prev_store) r_store_runs++;
        end
        if (pe_init) begin
          r_init_cnt++;
          r_last_init = cyc;
          if (!prev_init) r_init_runs++;
        end
        prev_store = pe_store_S;
        prev_init  = pe_init;
        if (cyc == last_acc + 1) r_qready_late = q_ready;
        if (!busy && r_done_cyc < 0) r_busy_drop = 1'b1;
        if (done) begin
          r_done_cnt++;
          if (r_done_cyc < 0) begin
            r_done_cyc = cyc; r_err = err; r_best = best_score; r_col = best_col;
          end
        end
        if (r_done_cyc >= 0 && cyc == r_done_cyc + 1) r_busy_after = busy;
        if (r_done_cyc >= 0 && cyc >= r_done_cyc + 20) finished = 1'b1;

        start = start_busy && (cyc == 5);
        if (qi < N) begin
          if (gap_left > 0) begin
            q_valid = 1'b0; gap_left--;
          end else begin
            q_valid = 1'b1; q_base = qry[qi];
            if (q_ready) begin
              qi++; last_acc = cyc;
              gap_left = qrand ? int'($urandom_range(0, 3)) : qgap;
            end
          end
        end else begin
          q_valid = 1'b0;
        end
        if (ri < nsup) begin
          ref_valid = 1'b1; ref_base = refs[ri];
          if (ref_ready) ri++;
        end else begin
          ref_valid = 1'b0;
        end
        if (rst_after > 0 && ri == rst_after) rst = 1'b1;
      end
    end
    start = 1'b0; q_valid = 1'b0; ref_valid = 1'b0;
    n_cmp++;
    if (!finished) begin
      n_err++; r_timeout = 1'b1;
      $display("FAIL job_timeout: job did not finish within 3000 cycles (required done)");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({q_ready, ref_ready, pe_S, pe_store_S, pe_T, pe_init, pe_init_V, busy, done, err, best_score, best_col} !== 47'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h required 0", {q_ready, ref_ready, pe_S, pe_store_S, pe_T, pe_init, pe_init_V, busy, done, err, best_score, best_col});
    end
    n_cmp++;
    if ($signed(pe_init_E) !== -(2 ** (W - 2))) begin
      n_err++; $display("FAIL reset_init_E: got %0d required %0d", $signed(pe_init_E), -(2 ** (W - 2)));
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_acgt();
    int exp_s;
    for (int i = 0; i < N; i++) qry[i] = 2'(i);
    for (int i = 0; i < 4; i++) refs[i] = 2'(i);
    run_job(4, 4, 1, 1'b0, 1'b0, 0);
    n_cmp++;
    if (r_store_runs !== 1 || r_store_q.size() !== N) begin
      n_err++; $display("FAIL store_burst: runs=%0d count=%0d required 1 and %0d", r_store_runs, r_store_q.size(), N);
    end
    for (int j = 0; j < N && j < r_store_q.size(); j++) begin
      exp_s = N - 1 - j;
      n_cmp++;
      if (int'(r_store_q[j]) !== exp_s) begin
        n_err++; $display("FAIL store_seq[%0d]: got %0d required %0d", j, r_store_q[j], exp_s);
      end
    end
    n_cmp++;
    if (r_qready_late !== 1'b0) begin
      n_err++; $display("FAIL q_ready_drop: got %0b required 0 after last accept", r_qready_late);
    end
    n_cmp++;
    if (int'($signed(r_best)) !== 8 || r_col !== 16'd4 || r_err !== 1'b0) begin
      n_err++; $display("FAIL acgt_best: got score=%0d col=%0d err=%0b required 8 4 0", $signed(r_best), r_col, r_err);
    end
    n_cmp++;
    if (r_done_cyc - r_last_init !== N + 1 || r_done_cnt !== 1) begin
      n_err++; $display("FAIL acgt_drain: got lag=%0d dones=%0d required %0d 1", r_done_cyc - r_last_init, r_done_cnt, N + 1);
    end
    n_cmp++;
    if (r_busy_drop !== 1'b0 || r_busy_after !== 1'b0) begin
      n_err++; $display("FAIL acgt_busy: got drop=%0b after=%0b required 0 0", r_busy_drop, r_busy_after);
    end
  endtask

  task automatic test_ref_offset();
    logic [1:0] pat [8];
    int bs, bc;
    pat = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    for (int i = 0; i < N; i++) qry[i] = 2'(i);
    for (int i = 0; i < 8; i++) refs[i] = pat[i];
    model_best(8, bs, bc);
    run_job(8, 8, 0, 1'b1, 1'b0, 0);
    n_cmp++;
    if (int'($signed(r_best)) !== 8 || r_col !== 16'd6) begin
      n_err++; $display("FAIL offset_best: got score=%0d col=%0d required 8 6", $signed(r_best), r_col);
    end
    n_cmp++;
    if (int'($signed(r_best)) !== bs || int'(r_col) !== bc) begin
      n_err++; $display("FAIL offset_model: got score=%0d col=%0d required %0d %0d", $signed(r_best), r_col, bs, bc);
    end
    n_cmp++;
    if (r_init_cnt !== 8 || r_init_runs !== 1) begin
      n_err++; $display("FAIL offset_init: got count=%0d runs=%0d required 8 1", r_init_cnt, r_init_runs);
    end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 8; i++) refs[i] = 2'($urandom_range(0, 3));
    run_job(8, 3, 0, 1'b1, 1'b0, 0);
    n_cmp++;
    if (r_init_cnt !== 3 || r_init_runs !== 1) begin
      n_err++; $display("FAIL underrun_init: got count=%0d runs=%0d required 3 1", r_init_cnt, r_init_runs);
    end
    n_cmp++;
    if (r_err !== 1'b1 || r_done_cnt !== 1) begin
      n_err++; $display("FAIL underrun_err: got err=%0b dones=%0d required 1 1", r_err, r_done_cnt);
    end
    n_cmp++;
    if (r_done_cyc - r_last_init !== N + 2) begin
      n_err++; $display("FAIL underrun_drain: got lag=%0d required %0d", r_done_cyc - r_last_init, N + 2);
    end
  endtask

  task automatic test_zero_len();
    for (int i = 0; i < N; i++) qry[i] = 2'($urandom_range(0, 3));
    run_job(0, 0, 0, 1'b1, 1'b1, 0);
    n_cmp++;
    if (r_init_cnt !== 0 || r_store_q.size() !== N) begin
      n_err++; $display("FAIL zero_len_phases: got inits=%0d stores=%0d required 0 %0d", r_init_cnt, r_store_q.size(), N);
    end
    n_cmp++;
    if (r_best !== '0 || r_col !== '0 || r_err !== 1'b0) begin
      n_err++; $display("FAIL zero_len_best: got score=%0d col=%0d err=%0b required 0 0 0", $signed(r_best), r_col, r_err);
    end
    n_cmp++;
    if (r_done_cnt !== 1) begin
      n_err++; $display("FAIL start_while_busy: got %0d done pulses required 1", r_done_cnt);
    end
    n_cmp++;
    if (r_done_cyc - r_last_store !== N + 1) begin
      n_err++; $display("FAIL zero_len_drain: got lag=%0d required %0d", r_done_cyc - r_last_store, N + 1);
    end
  endtask

  task automatic test_reset_mid_run();
    int bs, bc, len;
    for (int i = 0; i < 8; i++) refs[i] = 2'($urandom_range(0, 3));
    run_job(8, 8, 0, 1'b1, 1'b0, 2);
    n_cmp++;
    if (r_rst_outs !== 47'd0 || $signed(r_rst_E) !== -(2 ** (W - 2))) begin
      n_err++; $display("FAIL mid_run_reset: got outs=%h init_E=%0d required 0 %0d", r_rst_outs, $signed(r_rst_E), -(2 ** (W - 2)));
    end
    n_cmp++;
    if (r_done_cnt !== 0) begin
      n_err++; $display("FAIL mid_run_no_done: got %0d done pulses required 0", r_done_cnt);
    end
    for (int i = 0; i < N; i++) qry[i] = 2'($urandom_range(0, 3));
    len = 10;
    for (int i = 0; i < len; i++) refs[i] = 2'($urandom_range(0, 3));
    model_best(len, bs, bc);
    run_job(len, len, 0, 1'b1, 1'b0, 0);
    n_cmp++;
    if (int'($signed(r_best)) !== bs || int'(r_col) !== bc || r_err !== 1'b0 || r_done_cnt !== 1) begin
      n_err++; $display("FAIL after_reset_job: got score=%0d col=%0d err=%0b dones=%0d required %0d %0d 0 1", $signed(r_best), r_col, r_err, r_done_cnt, bs, bc);
    end
  endtask

  task automatic test_random();
    int bs, bc, len;
    for (int t = 0; t < 8; t++) begin
      len = int'($urandom_range(1, 20));
      for (int i = 0; i < N; i++) qry[i] = 2'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) refs[i] = 2'($urandom_range(0, 3));
      if (t == 0) for (int i = 0; i < len; i++) refs[i] = qry[i % N];
      model_best(len, bs, bc);
      run_job(len, len, 0, 1'b1, 1'b0, 0);
      n_cmp++;
      if (int'($signed(r_best)) !== bs || int'(r_col) !== bc) begin
        n_err++; $display("FAIL random_best[%0d]: got score=%0d col=%0d required %0d %0d", t, $signed(r_best), r_col, bs, bc);
      end
      n_cmp++;
      if (r_init_cnt !== len || r_err !== 1'b0 || r_done_cnt !== 1) begin
        n_err++; $display("FAIL random_job[%0d]: got inits=%0d err=%0b dones=%0d required %0d 0 1", t, r_init_cnt, r_err, r_done_cnt, len);
      end
      for (int j = 0; j < N && j < r_store_q.size(); j++) begin
        n_cmp++;
        if (r_store_q[j] !== qry[N - 1 - j]) begin
          n_err++; $display("FAIL random_store[%0d][%0d]: got %0d required %0d", t, j, r_store_q[j], qry[N - 1 - j]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ref_len = '0;
    q_valid = 1'b0; q_base = 2'd0; ref_valid = 1'b0; ref_base = 2'd0;
    test_reset();
    test_load_acgt();
    test_ref_offset();
    test_underrun();
    test_zero_len();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
